// File: rtl/cp0_pkg.sv
// cp0_pkg: cause codes, CP0 register numbers, Status bit positions and sequencer states
package cp0_pkg;
    localparam logic [4:0] CODE_SYS = 5'b01000;
    localparam logic [4:0] CODE_BRK = 5'b01001;
    localparam logic [4:0] CODE_TEQ = 5'b01101;
    localparam logic [4:0] CODE_INT = 5'b00000;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC = 5'd14;
    localparam int ST_IE = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_INT = 4;
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STAT, E_STAT, JUMP} state_t;
endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// cp0_exc_sequencer_if: decode requests in, CP0 write port and PC redirect out
interface cp0_exc_sequencer_if;
    logic syscall_req;
    logic break_req;
    logic teq_req;
    logic intr;
    logic eret_req;
    logic [31:0] cur_pc;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic cp0_we;
    logic [4:0] cp0_waddr;
    logic [31:0] cp0_wdata;
    logic stall;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0] exc_code;
    modport master (
        output syscall_req, break_req, teq_req, intr, eret_req, cur_pc, status_in, epc_in,
        input cp0_we, cp0_waddr, cp0_wdata, stall, redirect_valid, redirect_pc, exc_code
    );
    modport slave (
        input syscall_req, break_req, teq_req, intr, eret_req, cur_pc, status_in, epc_in,
        output cp0_we, cp0_waddr, cp0_wdata, stall, redirect_valid, redirect_pc, exc_code
    );
endinterface

// File: rtl/cp0_exc_prio.sv
// cp0_exc_prio: masks requests against Status and picks one: teq > break > syscall > eret > intr
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        intr,
    input  logic        eret_req,
    input  logic [31:0] status_in,
    output logic        take,
    output logic        is_eret,
    output logic [4:0]  code
);
    logic ie, t, b, s, i;
    assign ie = status_in[ST_IE];
    assign t = teq_req & ie & status_in[ST_TEQ];
    assign b = break_req & ie & status_in[ST_BRK];
    assign s = syscall_req & ie & status_in[ST_SYS];
    assign i = intr & ie & status_in[ST_INT];
    // eret is never masked but still outranks only the interrupt
    assign is_eret = eret_req & ~(t | b | s);
    assign take = t | b | s | (i & ~eret_req);
    assign code = t ? CODE_TEQ : b ? CODE_BRK : s ? CODE_SYS : CODE_INT;
endmodule

// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer: runs the EPC/Cause/Status write sequence for exceptions and ERET,
// then pulses a one-cycle PC redirect
module cp0_exc_sequencer
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter int SHIFT_AMT = 5
) (
    input logic clk,
    input logic rst,
    cp0_exc_sequencer_if.slave bus
);
    state_t state, next;
    logic take, is_eret, eret_q;
    logic [4:0] code, code_q;
    logic [31:0] pc_q;
    cp0_exc_prio u_prio (
        .syscall_req(bus.syscall_req),
        .break_req(bus.break_req),
        .teq_req(bus.teq_req),
        .intr(bus.intr),
        .eret_req(bus.eret_req),
        .status_in(bus.status_in),
        .take(take),
        .is_eret(is_eret),
        .code(code)
    );
    assign bus.exc_code = code_q;
    always_comb begin
        next = state;
        bus.cp0_we = 1'b0;
        bus.cp0_waddr = '0;
        bus.cp0_wdata = '0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        case (state)
            IDLE: begin
                bus.stall = (take | is_eret) & ~rst;
                next = take ? W_EPC : is_eret ? E_STAT : IDLE;
            end
            W_EPC: begin
                bus.stall = 1'b1;
                bus.cp0_we = 1'b1;
                bus.cp0_waddr = REG_EPC;
                bus.cp0_wdata = pc_q;
                next = W_CAUSE;
            end
            W_CAUSE: begin
                bus.stall = 1'b1;
                bus.cp0_we = 1'b1;
                bus.cp0_waddr = REG_CAUSE;
                bus.cp0_wdata = {25'b0, code_q, 2'b00};
                next = W_STAT;
            end
            W_STAT: begin
                bus.stall = 1'b1;
                bus.cp0_we = 1'b1;
                bus.cp0_waddr = REG_STATUS;
                bus.cp0_wdata = bus.status_in << SHIFT_AMT;
                next = JUMP;
            end
            E_STAT: begin
                bus.stall = 1'b1;
                bus.cp0_we = 1'b1;
                bus.cp0_waddr = REG_STATUS;
                bus.cp0_wdata = bus.status_in >> SHIFT_AMT;
                next = JUMP;
            end
            JUMP: begin
                bus.stall = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = eret_q ? bus.epc_in : EXC_VECTOR;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc_q <= '0;
            code_q <= '0;
            eret_q <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && take) begin
                pc_q <= bus.cur_pc;
                code_q <= code;
                eret_q <= 1'b0;
            end else if (state == IDLE && is_eret) begin
                code_q <= '0;
                eret_q <= 1'b1;
            end else if (state == JUMP) begin
                pc_q <= '0;
                code_q <= '0;
                eret_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb_cp0_exc_sequencer: directed vector table plus hand sequences for reset abort and level interrupt
module tb_cp0_exc_sequencer;
    import cp0_pkg::*;
    typedef struct {
        logic sys, brk, teq, intr, eret;
        logic [31:0] pc, status, epc;
        int kind;
        logic [4:0] code;
        logic [31:0] cause_w, stat_w, rpc;
    } vec_t;
    logic clk, rst;
    int total, bad;
    logic cw;
    logic [4:0] ca;
    logic [31:0] cd;
    vec_t vt[10];
    cp0_exc_sequencer_if bus();
    cp0_exc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk)
        if (!rst && dut.state != IDLE)
            assert (!(bus.syscall_req | bus.break_req | bus.teq_req | bus.eret_req))
            else $error("request arrived outside IDLE");
    task automatic chk(input string nm, input logic stl, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic rv, input logic [31:0] rpc, input logic [4:0] ec);
        total++;
        cw = bus.cp0_we;
        ca = bus.cp0_waddr;
        cd = bus.cp0_wdata;
        if ({bus.stall, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.redirect_valid, bus.redirect_pc, bus.exc_code}
            !== {stl, we, a, d, rv, rpc, ec}) begin
            bad++;
            $display("FAIL %s: got stall=%b we=%b addr=%0d data=%h rv=%b rpc=%h code=%h want stall=%b we=%b addr=%0d data=%h rv=%b rpc=%h code=%h",
                     nm, bus.stall, bus.cp0_we, bus.cp0_waddr, bus.cp0_wdata, bus.redirect_valid,
                     bus.redirect_pc, bus.exc_code, stl, we, a, d, rv, rpc, ec);
        end
    endtask
    // check at negedge, then let the modelled CP0 register file absorb any write at the edge
    task automatic cyc(input string nm, input logic stl, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic rv, input logic [31:0] rpc, input logic [4:0] ec);
        @(negedge clk);
        chk(nm, stl, we, a, d, rv, rpc, ec);
        @(posedge clk);
        #1;
        if (cw && ca == 5'd12) bus.status_in = cd;
        if (cw && ca == 5'd14) bus.epc_in = cd;
    endtask
    task automatic clr();
        bus.syscall_req = 0;
        bus.break_req = 0;
        bus.teq_req = 0;
        bus.eret_req = 0;
        bus.intr = 0;
    endtask
    initial begin
        total = 0;
        bad = 0;
        vt[0] = '{1, 0, 0, 0, 0, 32'h00400020, 32'h0000000F, 32'h0, 1, 5'h08, 32'h00000020, 32'h000001E0, 32'h00400004};
        vt[1] = '{0, 1, 0, 0, 0, 32'h00400028, 32'h0000000B, 32'h0, 0, 5'h00, 32'h0, 32'h0, 32'h0};
        vt[2] = '{1, 0, 1, 1, 0, 32'h00400030, 32'h0000001F, 32'h0, 1, 5'h0D, 32'h00000034, 32'h000003E0, 32'h00400004};
        vt[3] = '{0, 0, 0, 0, 1, 32'h00400034, 32'h000001E0, 32'h00400024, 2, 5'h00, 32'h0, 32'h0000000F, 32'h00400024};
        vt[4] = '{0, 1, 0, 0, 0, 32'h00400040, 32'h00000005, 32'h0, 1, 5'h09, 32'h00000024, 32'h000000A0, 32'h00400004};
        vt[5] = '{1, 0, 0, 0, 0, 32'h00400044, 32'h0000001E, 32'h0, 0, 5'h00, 32'h0, 32'h0, 32'h0};
        vt[6] = '{0, 1, 0, 0, 1, 32'h00400050, 32'h00000007, 32'h00400200, 1, 5'h09, 32'h00000024, 32'h000000E0, 32'h00400004};
        vt[7] = '{0, 0, 0, 1, 1, 32'h00400054, 32'h00000011, 32'h00400100, 2, 5'h00, 32'h0, 32'h00000000, 32'h00400100};
        vt[8] = '{1, 0, 1, 0, 0, 32'h00400060, 32'h00000007, 32'h0, 1, 5'h08, 32'h00000020, 32'h000000E0, 32'h00400004};
        vt[9] = '{0, 0, 0, 0, 0, 32'h00400064, 32'h0000001F, 32'h0, 0, 5'h00, 32'h0, 32'h0, 32'h0};
        clr();
        bus.cur_pc = '0;
        bus.status_in = '0;
        bus.epc_in = '0;
        rst = 1;
        @(negedge clk);
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 10; i++) begin
            bus.syscall_req = vt[i].sys;
            bus.break_req = vt[i].brk;
            bus.teq_req = vt[i].teq;
            bus.intr = vt[i].intr;
            bus.eret_req = vt[i].eret;
            bus.cur_pc = vt[i].pc;
            bus.status_in = vt[i].status;
            bus.epc_in = vt[i].epc;
            if (vt[i].kind == 0) begin
                cyc($sformatf("v%0d_drop", i), 0, 0, 0, 0, 0, 0, 0);
                clr();
            end else if (vt[i].kind == 1) begin
                cyc($sformatf("v%0d_accept", i), 1, 0, 0, 0, 0, 0, 0);
                clr();
                cyc($sformatf("v%0d_epc", i), 1, 1, 14, vt[i].pc, 0, 0, vt[i].code);
                cyc($sformatf("v%0d_cause", i), 1, 1, 13, vt[i].cause_w, 0, 0, vt[i].code);
                cyc($sformatf("v%0d_status", i), 1, 1, 12, vt[i].stat_w, 0, 0, vt[i].code);
                cyc($sformatf("v%0d_jump", i), 1, 0, 0, 0, 1, vt[i].rpc, vt[i].code);
            end else begin
                cyc($sformatf("v%0d_eret_accept", i), 1, 0, 0, 0, 0, 0, 0);
                clr();
                cyc($sformatf("v%0d_eret_status", i), 1, 1, 12, vt[i].stat_w, 0, 0, 0);
                cyc($sformatf("v%0d_eret_jump", i), 1, 0, 0, 0, 1, vt[i].rpc, 0);
            end
            cyc($sformatf("v%0d_idle", i), 0, 0, 0, 0, 0, 0, 0);
        end
        // reset during W_CAUSE aborts the sequence
        bus.status_in = 32'h0000000F;
        bus.cur_pc = 32'h00400080;
        bus.syscall_req = 1;
        cyc("rst_accept", 1, 0, 0, 0, 0, 0, 0);
        clr();
        cyc("rst_epc", 1, 1, 14, 32'h00400080, 0, 0, 5'h08);
        #1 rst = 1;
        #1 chk("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 4; k++) cyc($sformatf("rst_after%0d", k), 0, 0, 0, 0, 0, 0, 0);
        // level interrupt: taken once, Status shift clears IE so it is not re-taken
        bus.status_in = 32'h00000011;
        bus.cur_pc = 32'h00400070;
        bus.intr = 1;
        cyc("intr_accept", 1, 0, 0, 0, 0, 0, 0);
        cyc("intr_epc", 1, 1, 14, 32'h00400070, 0, 0, 5'h00);
        cyc("intr_cause", 1, 1, 13, 32'h00000000, 0, 0, 5'h00);
        cyc("intr_status", 1, 1, 12, 32'h00000220, 0, 0, 5'h00);
        cyc("intr_jump", 1, 0, 0, 0, 1, 32'h00400004, 5'h00);
        cyc("intr_held0", 0, 0, 0, 0, 0, 0, 0);
        cyc("intr_held1", 0, 0, 0, 0, 0, 0, 0);
        clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
